// File: rtl/cpu_defs.sv
// Shared definitions for the memory-interface controller: FSM state encoding,
// default parameters and the per-state control-output decode.
package cpu_defs;

    // Default datapath width; informational only.
    localparam int unsigned BitsDefault = 32;

    // Default number of wait cycles allowed for mem_ready before aborting.
    localparam int unsigned TimeoutDefault = 15;

    // Controller states.
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAddr    = 3'd1,
        StWrLoad  = 3'd2,
        StRdWait  = 3'd3,
        StWrWait  = 3'd4,
        StRdLatch = 3'd5,
        StDone    = 3'd6,
        StErr     = 3'd7
    } state_e;

    // Control outputs, bundled so they can be registered together.
    typedef struct packed {
        logic busy;
        logic done;
        logic error;
        logic mar_in;
        logic mdr_read;
        logic mdr_enable;
        logic mem_rd;
        logic mem_wr;
    } ctrl_out_t;

    // Moore output decode: every output not listed for a state stays 0, which
    // also guarantees mem_rd and mem_wr are never high together.
    function automatic ctrl_out_t decode_outputs(state_e st);
        ctrl_out_t o;
        o = '0;
        case (st)
            StIdle: begin
            end
            StAddr: begin
                o.busy   = 1'b1;
                o.mar_in = 1'b1;
            end
            StWrLoad: begin
                o.busy       = 1'b1;
                o.mdr_enable = 1'b1;
                o.mdr_read   = 1'b0;
            end
            StRdWait: begin
                o.busy   = 1'b1;
                o.mem_rd = 1'b1;
            end
            StWrWait: begin
                o.busy   = 1'b1;
                o.mem_wr = 1'b1;
            end
            StRdLatch: begin
                o.busy       = 1'b1;
                o.mem_rd     = 1'b1;
                o.mdr_enable = 1'b1;
                o.mdr_read   = 1'b1;
            end
            StDone: begin
                o.busy = 1'b1;
                o.done = 1'b1;
            end
            StErr: begin
                o.busy  = 1'b1;
                o.error = 1'b1;
            end
            default: begin
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for the memory handshake. Cleared by start when a wait
// state is entered, advanced by tick on every wait cycle without mem_ready,
// and flags expiry on the last permitted wait cycle.
module mem_wait_timer
    import cpu_defs::*;
#(
    parameter int unsigned TIMEOUT = TimeoutDefault
) (
    input  logic clk,
    input  logic clear,
    input  logic start,
    input  logic tick,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    // The counter starts at 0 in the first wait cycle, so the last permitted
    // wait cycle sees TIMEOUT-1.
    localparam logic [CntW-1:0] LastCount = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;

    // Next count: restart on entry to a wait state, otherwise advance while not ready.
    always_comb begin
        count_d = count_q;
        if (start) begin
            count_d = '0;
        end else if (tick && !expired) begin
            count_d = count_q + CntW'(1);
        end
    end

    // Counter register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LastCount);

endmodule

// File: rtl/mem_ctrl.sv
// Memory-interface controller: sequences MAR/MDR loads and memory read/write
// strobes for a single outstanding request, with a bounded wait for mem_ready.
module mem_ctrl
    import cpu_defs::*;
#(
    parameter int unsigned BITS    = BitsDefault,
    parameter int unsigned TIMEOUT = TimeoutDefault
) (
    input  logic clk,
    input  logic clear,
    input  logic req_rd,
    input  logic req_wr,
    input  logic mem_ready,
    output logic busy,
    output logic done,
    output logic error,
    output logic mar_in,
    output logic mdr_read,
    output logic mdr_enable,
    output logic mem_rd,
    output logic mem_wr
);

    // Reject degenerate configurations at elaboration time.
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_ctrl: TIMEOUT must be at least 1");
    end
    if (BITS < 1) begin : g_bad_bits
        $error("mem_ctrl: BITS must be at least 1");
    end

    state_e    state_q;
    state_e    state_d;
    logic      op_wr_q;
    logic      op_wr_d;
    ctrl_out_t out_q;
    ctrl_out_t out_d;

    logic timer_start;
    logic timer_tick;
    logic timer_expired;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .clear   (clear),
        .start   (timer_start),
        .tick    (timer_tick),
        .expired (timer_expired)
    );

    // Next-state logic; requests are only looked at in StIdle, so anything
    // arriving while busy is dropped rather than queued.
    always_comb begin
        state_d = state_q;
        op_wr_d = op_wr_q;
        unique case (state_q)
            StIdle: begin
                if (req_rd) begin
                    op_wr_d = 1'b0;
                    state_d = StAddr;
                end else if (req_wr) begin
                    op_wr_d = 1'b1;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                state_d = op_wr_q ? StWrLoad : StRdWait;
            end
            StWrLoad: begin
                state_d = StWrWait;
            end
            StRdWait: begin
                // Ready takes priority over expiry on the final wait cycle.
                if (mem_ready) begin
                    state_d = StRdLatch;
                end else if (timer_expired) begin
                    state_d = StErr;
                end
            end
            StWrWait: begin
                if (mem_ready) begin
                    state_d = StDone;
                end else if (timer_expired) begin
                    state_d = StErr;
                end
            end
            StRdLatch: begin
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            StErr: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are decoded from the next state so the registered copy
        // lines up with state_q.
        out_d = decode_outputs(state_d);
    end

    // Timer control: restart on entry to a wait state, count unanswered wait cycles.
    always_comb begin
        timer_start = ((state_d == StRdWait) && (state_q != StRdWait)) ||
                      ((state_d == StWrWait) && (state_q != StWrWait));
        timer_tick  = ((state_q == StRdWait) || (state_q == StWrWait)) && !mem_ready;
    end

    // FSM state, latched operation and registered outputs.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= StIdle;
            op_wr_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            op_wr_q <= op_wr_d;
            out_q   <= out_d;
        end
    end

    assign busy       = out_q.busy;
    assign done       = out_q.done;
    assign error      = out_q.error;
    assign mar_in     = out_q.mar_in;
    assign mdr_read   = out_q.mdr_read;
    assign mdr_enable = out_q.mdr_enable;
    assign mem_rd     = out_q.mem_rd;
    assign mem_wr     = out_q.mem_wr;

    // Read and write strobes must never overlap.
    mutex_rd_wr : assert property (@(posedge clk) disable iff (!clear) !(mem_rd && mem_wr));

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl. Each transaction's expected per-cycle
// output trace is derived from the operation and the wait cycle on which
// mem_ready arrives; the DUT is compared against it cycle by cycle.
module tb_mem_ctrl;

    localparam int unsigned TO = 15;

    // Output vector order: {busy, done, error, mar_in, mdr_read, mdr_enable, mem_rd, mem_wr}
    localparam logic [7:0] OIdle    = 8'b0000_0000;
    localparam logic [7:0] OAddr    = 8'b1001_0000;
    localparam logic [7:0] OWrLoad  = 8'b1000_0100;
    localparam logic [7:0] ORdWait  = 8'b1000_0010;
    localparam logic [7:0] OWrWait  = 8'b1000_0001;
    localparam logic [7:0] ORdLatch = 8'b1000_1110;
    localparam logic [7:0] ODone    = 8'b1100_0000;
    localparam logic [7:0] OErr     = 8'b1010_0000;

    logic clk;
    logic clear;
    logic req_rd;
    logic req_wr;
    logic mem_ready;
    logic busy;
    logic done;
    logic error;
    logic mar_in;
    logic mdr_read;
    logic mdr_enable;
    logic mem_rd;
    logic mem_wr;

    int checks;
    int errors;

    logic [7:0] exp_q[$];

    mem_ctrl #(
        .BITS    (32),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .clear      (clear),
        .req_rd     (req_rd),
        .req_wr     (req_wr),
        .mem_ready  (mem_ready),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .mar_in     (mar_in),
        .mdr_read   (mdr_read),
        .mdr_enable (mdr_enable),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {busy, done, error, mar_in, mdr_read, mdr_enable, mem_rd, mem_wr};
    endfunction

    // Reference trace: one entry per cycle after the request-sampling edge.
    // ready_at is the 1-based wait cycle carrying mem_ready; outside 1..TO the
    // memory never answers in time.
    task automatic build_expected(input bit is_wr, input int ready_at, output int wait_start,
                                  output int nwait);
        bit ok;
        ok = (ready_at >= 1) && (ready_at <= int'(TO));
        nwait = ok ? ready_at : int'(TO);
        wait_start = is_wr ? 3 : 2;
        exp_q.delete();
        exp_q.push_back(OAddr);
        if (is_wr) exp_q.push_back(OWrLoad);
        for (int i = 0; i < nwait; i++) exp_q.push_back(is_wr ? OWrWait : ORdWait);
        if (ok) begin
            if (!is_wr) exp_q.push_back(ORdLatch);
            exp_q.push_back(ODone);
        end else begin
            exp_q.push_back(OErr);
        end
    endtask

    // One transaction starting from an IDLE cycle. Outputs are checked on the
    // falling edge, where inputs for the coming rising edge are also driven.
    task automatic run_txn(input string name, input bit do_rd, input bit do_wr, input int ready_at,
                           input bit tie_ready, input bit noise);
        int wait_start;
        int nwait;
        int len;
        bit is_wr;
        logic [7:0] obs;
        is_wr = !do_rd;
        build_expected(is_wr, ready_at, wait_start, nwait);
        len = exp_q.size();
        @(negedge clk);
        req_rd    = do_rd;
        req_wr    = do_wr;
        mem_ready = tie_ready ? 1'b1 : 1'($urandom_range(0, 1));
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            obs = outs();
            checks++;
            if (obs !== exp_q[c-1]) begin
                errors++;
                $display("FAIL %s cycle %0d: got %b expected %b", name, c, obs, exp_q[c-1]);
            end
            req_rd = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            req_wr = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (tie_ready) begin
                mem_ready = 1'b1;
            end else if (c >= wait_start && c < wait_start + nwait) begin
                mem_ready = ((c - wait_start + 1) == ready_at);
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
        end
    endtask

    // Two quiet cycles: controller back in IDLE and accepting nothing.
    task automatic check_idle(input string name);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (outs() !== OIdle) begin
                errors++;
                $display("FAIL %s idle %0d: got %b expected %b", name, i, outs(), OIdle);
            end
            req_rd    = 1'b0;
            req_wr    = 1'b0;
            mem_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        req_rd    = 1'b1;
        req_wr    = 1'b1;
        mem_ready = 1'b1;
        clear     = 1'b1;
        #1 clear  = 1'b0;
        #1;
        checks++;
        if (outs() !== OIdle) begin
            errors++;
            $display("FAIL reset_async: got %b expected %b", outs(), OIdle);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (outs() !== OIdle) begin
            errors++;
            $display("FAIL reset_held: got %b expected %b", outs(), OIdle);
        end
        @(negedge clk);
        req_rd    = 1'b0;
        req_wr    = 1'b0;
        mem_ready = 1'b0;
        clear     = 1'b1;
        check_idle("reset_release");
    endtask

    task automatic test_read_fast();
        run_txn("read_fast", 1'b1, 1'b0, 1, 1'b1, 1'b0);
        check_idle("read_fast");
    endtask

    task automatic test_write_wait3();
        run_txn("write_wait3", 1'b0, 1'b1, 4, 1'b0, 1'b0);
        check_idle("write_wait3");
    endtask

    task automatic test_timeout();
        run_txn("timeout_rd", 1'b1, 1'b0, 0, 1'b0, 1'b0);
        check_idle("timeout_rd");
        run_txn("timeout_wr", 1'b0, 1'b1, 0, 1'b0, 1'b0);
        check_idle("timeout_wr");
    endtask

    task automatic test_both_requests();
        // Both requests together, then random requests (including req_wr)
        // while busy; only the read may run.
        run_txn("both_req", 1'b1, 1'b1, 3, 1'b0, 1'b1);
        check_idle("both_req");
    endtask

    task automatic test_ready_final();
        run_txn("ready_final_rd", 1'b1, 1'b0, int'(TO), 1'b0, 1'b0);
        run_txn("ready_final_wr", 1'b0, 1'b1, int'(TO), 1'b0, 1'b0);
        check_idle("ready_final");
    endtask

    task automatic test_clear_mid();
        @(negedge clk);
        req_wr    = 1'b1;
        mem_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            req_wr = 1'b0;
        end
        checks++;
        if (outs() !== OWrWait) begin
            errors++;
            $display("FAIL clear_mid_setup: got %b expected %b", outs(), OWrWait);
        end
        #1 clear = 1'b0;
        #1;
        checks++;
        if (outs() !== OIdle) begin
            errors++;
            $display("FAIL clear_mid_async: got %b expected %b", outs(), OIdle);
        end
        @(posedge clk);
        #2 clear = 1'b1;
        checks++;
        if (outs() !== OIdle) begin
            errors++;
            $display("FAIL clear_mid_held: got %b expected %b", outs(), OIdle);
        end
        run_txn("clear_mid_rd", 1'b1, 1'b0, 1, 1'b1, 1'b0);
        check_idle("clear_mid_rd");
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_0", 1'b1, 1'b0, 2, 1'b0, 1'b1);
        run_txn("b2b_1", 1'b0, 1'b1, 1, 1'b0, 1'b1);
        run_txn("b2b_2", 1'b1, 1'b0, 0, 1'b0, 1'b1);
        check_idle("b2b");
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            int  kind;
            bit  rd;
            bit  wr;
            kind = int'($urandom_range(0, 2));
            rd   = (kind != 1);
            wr   = (kind != 0);
            run_txn("random", rd, wr, int'($urandom_range(0, TO + 2)), 1'b0, 1'b1);
        end
        check_idle("random");
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        clear     = 1'b1;
        req_rd    = 1'b0;
        req_wr    = 1'b0;
        mem_ready = 1'b0;
        test_reset();
        test_read_fast();
        test_write_wait3();
        test_timeout();
        test_both_requests();
        test_ready_final();
        test_clear_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter BITS, default 32: datapath width; informational only, no port width depends on it.
REQ-002 Parameter TIMEOUT, default 15: maximum wait cycles for mem_ready before abort.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 clear  input  1  reset; asynchronous, active-low.
REQ-005 req_rd  input  1  control-unit request for a memory read; sampled only in IDLE.
REQ-006 req_wr  input  1  control-unit request for a memory write; sampled only in IDLE.
REQ-007 mem_ready  input  1  memory completion acknowledge; ignored outside the wait states.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse on successful completion.
REQ-010 error  output  1  one-cycle pulse on timeout abort.
REQ-011 mar_in  output  1  MAR load enable; MAR captures the address from the bus.
REQ-012 mdr_read  output  1  MDR input select: 1 selects MDataIn, 0 selects busMuxOut.
REQ-013 mdr_enable  output  1  MDR load enable.
REQ-014 mem_rd  output  1  memory read strobe.
REQ-015 mem_wr  output  1  memory write strobe.

Function
REQ-016 The FSM SHALL have states IDLE, ADDR, WR_LOAD, RD_WAIT, WR_WAIT, RD_LATCH, DONE and ERR; all outputs are Moore, decoded from state only.
REQ-017 In IDLE, a sampled req_rd or req_wr SHALL latch the operation and move to ADDR; req_rd wins when both are high.
REQ-018 Requests while busy=1 SHALL be ignored, not queued.
REQ-019 ADDR (1 cycle): mar_in=1; then RD_WAIT for a read, WR_LOAD for a write.
REQ-020 WR_LOAD (1 cycle): mdr_enable=1, mdr_read=0; then WR_WAIT.
REQ-021 RD_WAIT: mem_rd=1; mem_ready=1 moves to RD_LATCH.
REQ-022 RD_LATCH (1 cycle): mem_rd=1, mdr_enable=1, mdr_read=1; then DONE.
REQ-023 WR_WAIT: mem_wr=1; mem_ready=1 moves to DONE.
REQ-024 The wait counter SHALL clear on entry to RD_WAIT/WR_WAIT and increment each wait cycle without ready; width $clog2(TIMEOUT+1).
REQ-025 When the counter equals TIMEOUT-1 and mem_ready=0, the FSM SHALL go to ERR; if mem_ready=1 on that same cycle, success wins.
REQ-026 DONE (1 cycle): done=1, busy=1; then IDLE. ERR (1 cycle): error=1, busy=1, done=0; then IDLE.
REQ-027 Read and write latency from the request-sampling edge to done high SHALL be 4 cycles when mem_ready is high in the first wait cycle, plus 1 cycle per extra wait cycle.
REQ-028 Outputs not listed for a state SHALL be 0; mem_rd and mem_wr SHALL never be high together.

Reset
REQ-029 clear=0 SHALL asynchronously force IDLE, counter 0, latched op 0, and all outputs 0, including mid-transaction.
REQ-030 After clear deasserts, the first request SHALL be accepted at the next rising edge.

Structure
REQ-031 State encodings and the TIMEOUT default SHALL live in the shared cpu_defs package/include.
REQ-032 The wait counter and timeout compare SHALL be one sub-module, mem_wait_timer (inputs clk, clear, start, tick; output expired).

Verification
REQ-033 Read, mem_ready tied high: req_rd pulse at edge 0 -> mar_in at cycle 1, mem_rd at cycles 2-3, mdr_enable+mdr_read at cycle 3, done at cycle 4.
REQ-034 Write, mem_ready high after 3 wait cycles: req_wr -> mar_in at cycle 1, mdr_enable with mdr_read=0 at cycle 2, mem_wr at cycles 3-6, done at cycle 7.
REQ-035 Timeout: req_rd, mem_ready held 0 -> mem_rd for exactly 15 cycles, error pulse for 1 cycle, done never high, IDLE afterwards.
REQ-036 req_rd and req_wr high together, then a req_wr pulse during RD_WAIT -> read sequence only, write ignored, busy low after DONE.
REQ-037 clear=0 asserted mid-WR_WAIT -> all outputs 0 immediately, without waiting for a clock edge; a new req_rd after release completes normally in 4 cycles.
REQ-038 mem_ready=1 coincident with the final timeout cycle -> done asserted, error stays 0.
